// File: rtl/multi_mixer.sv
// multi_mixer: quadrature encoders drive per-channel levels, mirrored to PWM.
// clk, reset (async, low); enc_a/enc_b per channel; load_*; level; pwm_out.
module mm_deb #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEB);
  localparam logic [CW-1:0] LAST = CW'(DEB - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        dout <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module multi_mixer #(
  parameter int NCH  = 3,
  parameter int W    = 8,
  parameter int DEB  = 4,
  parameter bit SAT  = 1'b1,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   enc_a,
  input  logic [NCH-1:0]   enc_b,
  input  logic             load_en,
  input  logic [2:0]       load_ch,
  input  logic [W-1:0]     load_val,
  output logic [NCH*W-1:0] level,
  output logic [NCH-1:0]   pwm_out
);
  localparam logic [W-1:0] MAXV  = '1;
  localparam logic [W:0]   STEPV = (W+1)'(STEP);

  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap = (cnt == MAXV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic         a_d;
    logic         b_d;
    logic         a_p;
    logic         b_p;
    logic         a_chg;
    logic         b_chg;
    logic         up;
    logic         dn;
    logic         ld;
    logic         pwm;
    logic [W:0]   inc;
    logic [W:0]   dec;
    logic [W-1:0] lvl;
    logic [W-1:0] lvl_nx;
    logic [W-1:0] shadow;

    mm_deb #(.DEB(DEB)) u_deb_a (
      .clk  (clk),
      .reset(reset),
      .din  (enc_a[i]),
      .dout (a_d)
    );

    mm_deb #(.DEB(DEB)) u_deb_b (
      .clk  (clk),
      .reset(reset),
      .din  (enc_b[i]),
      .dout (b_d)
    );

    // a moving alone is a detent; direction from a vs b
    assign a_chg = a_d ^ a_p;
    assign b_chg = b_d ^ b_p;
    assign up    = a_chg & ~b_chg & (a_d ^ b_d);
    assign dn    = a_chg & ~b_chg & ~(a_d ^ b_d);
    assign ld    = load_en && (load_ch == 3'(i));
    assign inc   = {1'b0, lvl} + STEPV;
    assign dec   = {1'b0, lvl} - STEPV;

    always_comb begin
      lvl_nx = lvl;
      if (ld) begin
        lvl_nx = load_val;
      end else if (up) begin
        lvl_nx = (SAT && inc[W]) ? MAXV : inc[W-1:0];
      end else if (dn) begin
        lvl_nx = (SAT && dec[W]) ? '0 : dec[W-1:0];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        a_p    <= 1'b0;
        b_p    <= 1'b0;
        lvl    <= '0;
        shadow <= '0;
        pwm    <= 1'b0;
      end else begin
        a_p <= a_d;
        b_p <= b_d;
        lvl <= lvl_nx;
        if (wrap) begin
          shadow <= lvl;
        end
        pwm <= (cnt < shadow);
      end
    end

    assign level[i*W +: W] = lvl;
    assign pwm_out[i]      = pwm;
  end
endmodule

// File: tb/tb_multi_mixer.sv
// tb_multi_mixer: random encoder/load traffic vs a level model,
// scoreboarded level changes, and per-period PWM duty counts.
module tb_multi_mixer;
  localparam int NCH  = 3;
  localparam int W    = 8;
  localparam int DEB  = 4;
  localparam int STEP = 1;
  localparam int MAXV = (1 << W) - 1;
  localparam int PER  = 1 << W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   enc_a = '0;
  logic [NCH-1:0]   enc_b = '0;
  logic             load_en = 1'b0;
  logic [2:0]       load_ch = '0;
  logic [W-1:0]     load_val = '0;
  logic [NCH*W-1:0] level_s;
  logic [NCH*W-1:0] level_w;
  logic [NCH-1:0]   pwm_s;
  logic [NCH-1:0]   pwm_w;

  int errors = 0;
  int checks = 0;
  int tcount;
  int lv_s[NCH];
  int lv_w[NCH];
  bit pa[NCH];
  bit pb[NCH];
  logic [NCH*W-1:0] q_s[$];
  logic [NCH*W-1:0] q_w[$];
  logic [NCH*W-1:0] last_s = '0;
  logic [NCH*W-1:0] last_w = '0;

  always #5 clk = ~clk;

  multi_mixer #(.NCH(NCH), .W(W), .DEB(DEB), .SAT(1'b1), .STEP(STEP)) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
    .level(level_s), .pwm_out(pwm_s)
  );

  multi_mixer #(.NCH(NCH), .W(W), .DEB(DEB), .SAT(1'b0), .STEP(STEP)) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
    .level(level_w), .pwm_out(pwm_w)
  );

  // edges since reset release; the PWM counter value follows from it
  always @(posedge clk or negedge reset) begin
    if (!reset) tcount <= 0;
    else tcount <= tcount + 1;
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (level_s !== last_s) begin
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sat_unexpected: got %h expected %h", level_s, last_s);
      end else begin
        check("sat_level", level_s, q_s.pop_front());
      end
      last_s = level_s;
    end
    if (level_w !== last_w) begin
      if (q_w.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wrap_unexpected: got %h expected %h", level_w, last_w);
      end else begin
        check("wrap_level", level_w, q_w.pop_front());
      end
      last_w = level_w;
    end
  end

  function automatic int upd(input int v, input int d, input bit sat);
    int r;
    r = v + d;
    if (sat) begin
      if (r < 0) r = 0;
      if (r > MAXV) r = MAXV;
    end else begin
      r = ((r % PER) + PER) % PER;
    end
    return r;
  endfunction

  // new a value against unchanged b: up on rise with b=0 or fall with b=1
  function automatic int dlt(input bit na, input bit b);
    if ((na && !b) || (!na && b)) return STEP;
    return -STEP;
  endfunction

  function automatic logic [NCH*W-1:0] pack(input int v[NCH]);
    logic [NCH*W-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction

  task automatic commit(input int ns[NCH], input int nw[NCH]);
    if (pack(ns) !== pack(lv_s)) q_s.push_back(pack(ns));
    if (pack(nw) !== pack(lv_w)) q_w.push_back(pack(nw));
    lv_s = ns;
    lv_w = nw;
  endtask

  task automatic drive_phase();
    for (int i = 0; i < NCH; i++) begin
      enc_a[i] = pa[i];
      enc_b[i] = pb[i];
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic check_levels(input string name);
    for (int i = 0; i < NCH; i++) begin
      check({name, "_sat"}, level_s[i*W +: W], lv_s[i]);
      check({name, "_wrap"}, level_w[i*W +: W], lv_w[i]);
    end
  endtask

  task automatic move(input logic [NCH-1:0] ta, input logic [NCH-1:0] tb,
                      input int hold);
    int ns[NCH];
    int nw[NCH];
    bit na;
    @(negedge clk);
    ns = lv_s;
    nw = lv_w;
    for (int i = 0; i < NCH; i++) begin
      na = pa[i] ^ ta[i];
      if (ta[i] && !tb[i]) begin
        ns[i] = upd(ns[i], dlt(na, pb[i]), 1'b1);
        nw[i] = upd(nw[i], dlt(na, pb[i]), 1'b0);
      end
      pa[i] = na;
      pb[i] = pb[i] ^ tb[i];
    end
    commit(ns, nw);
    drive_phase();
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic do_load(input int ch, input int val);
    int ns[NCH];
    int nw[NCH];
    @(negedge clk);
    ns = lv_s;
    nw = lv_w;
    if (ch < NCH) begin
      ns[ch] = val;
      nw[ch] = val;
    end
    commit(ns, nw);
    load_en  = 1'b1;
    load_ch  = 3'(ch);
    load_val = W'(val);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic glitch(input int ch, input bit on_b, input int k);
    @(negedge clk);
    if (on_b) enc_b[ch] = ~enc_b[ch];
    else enc_a[ch] = ~enc_a[ch];
    repeat (k) @(negedge clk);
    drive_phase();
    repeat (6) @(negedge clk);
  endtask

  task automatic align();
    @(negedge clk);
    while (tcount % PER != 0) @(negedge clk);
  endtask

  task automatic pwm_period(input string name);
    int hs[NCH];
    int hw[NCH];
    align();
    for (int i = 0; i < NCH; i++) begin
      hs[i] = 0;
      hw[i] = 0;
    end
    for (int k = 0; k < PER; k++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        hs[i] += int'(pwm_s[i]);
        hw[i] += int'(pwm_w[i]);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      check({name, "_sat"}, hs[i], lv_s[i]);
      check({name, "_wrap"}, hw[i], lv_w[i]);
    end
  endtask

  task automatic load_with_detent();
    int ns[NCH];
    int nw[NCH];
    bit na;
    settle();
    @(negedge clk);
    ns = lv_s;
    nw = lv_w;
    for (int i = 0; i < 2; i++) begin
      na = !pa[i];
      ns[i] = upd(ns[i], dlt(na, pb[i]), 1'b1);
      nw[i] = upd(nw[i], dlt(na, pb[i]), 1'b0);
      pa[i] = na;
    end
    ns[0] = 77;
    nw[0] = 77;
    commit(ns, nw);
    drive_phase();
    // 2 sync + DEB debounce edges, so the detent decodes on this cycle
    repeat (2 + DEB) @(negedge clk);
    load_en  = 1'b1;
    load_ch  = 3'd0;
    load_val = W'(77);
    @(negedge clk);
    load_en = 1'b0;
    settle();
    check_levels("load_over_detent");
  endtask

  task automatic pwm_midload();
    int ns[NCH];
    int nw[NCH];
    int hs;
    int hw;
    int old_s;
    int old_w;
    do_load(0, 200);
    settle();
    align();
    old_s = lv_s[0];
    old_w = lv_w[0];
    hs = 0;
    hw = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      hs += int'(pwm_s[0]);
      hw += int'(pwm_w[0]);
    end
    ns = lv_s;
    nw = lv_w;
    ns[0] = 64;
    nw[0] = 64;
    commit(ns, nw);
    load_en  = 1'b1;
    load_ch  = 3'd0;
    load_val = W'(64);
    for (int k = 0; k < PER - 100; k++) begin
      @(negedge clk);
      load_en = 1'b0;
      hs += int'(pwm_s[0]);
      hw += int'(pwm_w[0]);
    end
    check("pwm_old_duty_sat", hs, old_s);
    check("pwm_old_duty_wrap", hw, old_w);
    hs = 0;
    hw = 0;
    for (int k = 0; k < PER; k++) begin
      @(negedge clk);
      hs += int'(pwm_s[0]);
      hw += int'(pwm_w[0]);
    end
    check("pwm_new_duty_sat", hs, 64);
    check("pwm_new_duty_wrap", hw, 64);
  endtask

  task automatic reset_midop();
    int ns[NCH];
    int nw[NCH];
    settle();
    do_load(0, 200);
    do_load(1, 33);
    do_load(2, 9);
    settle();
    pwm_period("pwm_pre_reset");
    repeat (10) @(negedge clk);
    check("pwm_high_before_reset", pwm_s[0], 1);
    @(posedge clk);
    #3;
    for (int i = 0; i < NCH; i++) begin
      ns[i] = 0;
      nw[i] = 0;
    end
    commit(ns, nw);
    reset = 1'b0;
    #1;
    check("async_reset_level_sat", level_s, 0);
    check("async_reset_level_wrap", level_w, 0);
    check("async_reset_pwm_sat", pwm_s, 0);
    check("async_reset_pwm_wrap", pwm_w, 0);
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      pa[i] = 1'($urandom_range(0, 1));
      pb[i] = 1'($urandom_range(0, 1));
    end
    pa[0] = 1'b1;
    pb[0] = 1'b1;
    drive_phase();
    repeat (4) @(negedge clk);
    // debounced state restarts at 00: only a lone a rise counts
    ns = lv_s;
    nw = lv_w;
    for (int i = 0; i < NCH; i++) begin
      if (pa[i] && !pb[i]) begin
        ns[i] = upd(ns[i], dlt(1'b1, 1'b0), 1'b1);
        nw[i] = upd(nw[i], dlt(1'b1, 1'b0), 1'b0);
      end
    end
    commit(ns, nw);
    reset = 1'b1;
    settle();
    check_levels("after_reset");
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      lv_s[i] = 0;
      lv_w[i] = 0;
      pa[i]   = 1'b0;
      pb[i]   = 1'b0;
    end
    #2;
    reset = 1'b0;
    #20;
    check("reset_level_sat", level_s, 0);
    check("reset_level_wrap", level_w, 0);
    check("reset_pwm", {pwm_s, pwm_w}, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) move(3'b001, 3'b000, 10);
      else move(3'b000, 3'b001, 10);
    end
    settle();
    check("five_up_ch0", level_s[7:0], 5);
    check("five_up_others", level_s[23:8], 0);

    do_load(1, 254);
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) move(3'b010, 3'b000, 10);
      else move(3'b000, 3'b010, 10);
    end
    settle();
    check("sat_clamp_ch1", level_s[15:8], 255);
    check("wrap_ch1", level_w[15:8], 1);

    settle();
    glitch(2, 1'b0, 2);
    check("glitch_no_change", level_s[23:16], lv_s[2]);
    move(3'b100, 3'b000, DEB);
    settle();
    check_levels("deb_exact_hold");

    load_with_detent();
    do_load(5, 99);
    settle();
    check_levels("load_ch_out_of_range");

    pwm_midload();
    settle();

    for (int n = 0; n < 120; n++) begin
      int r;
      int v;
      logic [NCH-1:0] ta;
      logic [NCH-1:0] tb;
      r  = $urandom_range(0, 9);
      ta = NCH'($urandom);
      tb = NCH'($urandom);
      if (r < 6) begin
        move(ta, tb, $urandom_range(DEB, DEB + 6));
      end else if (r < 8) begin
        settle();
        case ($urandom_range(0, 4))
          0: v = 0;
          1: v = 1;
          2: v = MAXV - 1;
          3: v = MAXV;
          default: v = $urandom_range(0, MAXV);
        endcase
        do_load($urandom_range(0, 7), v);
      end else begin
        settle();
        glitch($urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)),
               $urandom_range(1, DEB - 1));
      end
    end
    settle();
    check_levels("random_end");
    pwm_period("pwm_random");

    reset_midop();
    for (int n = 0; n < 20; n++) begin
      move(NCH'($urandom), NCH'($urandom), $urandom_range(DEB, DEB + 6));
    end
    settle();
    check_levels("final");
    check("sat_queue_empty", q_s.size(), 0);
    check("wrap_queue_empty", q_w.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
